// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared encodings, drain FSM states and product helper for mac_row_dm
package mac_pkg;

  localparam logic [1:0] INST_NOP  = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  localparam int PROD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_DUMP
  } drain_state_t;

  // Activation arrives zero-extended and weight sign-extended; the caller
  // truncates to psum width, which gives the modulo-2^psum_bw wrap.
  function automatic logic signed [PROD_W-1:0] mac_product(
    input logic        [PROD_W-1:0] act,
    input logic signed [PROD_W-1:0] wgt
  );
    return $signed(act) * wgt;
  endfunction

endpackage

// File: rtl/mac_pe_dm.sv
// rtl/mac_pe_dm.sv - one dual-mode PE: weight/flag, OS accumulator, south psum and east chain
module mac_pe_dm
  import mac_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         inst,
  input  logic               mode,
  input  logic [bw-1:0]      data,
  input  logic [psum_bw-1:0] psum_n,
  input  logic               dump,
  output logic [1:0]         inst_e,
  output logic               mode_e,
  output logic [bw-1:0]      data_e,
  output logic [psum_bw-1:0] psum_s,
  output logic               valid
);

  logic [bw-1:0]      weight;
  logic               loaded;
  logic [psum_bw-1:0] acc;
  logic [bw-1:0]      mul_w;
  logic [psum_bw-1:0] prod;

  // OS takes its weight from the low bits of the north input, WS from the stationary register.
  always_comb begin
    mul_w = (mode == MODE_OS) ? psum_n[bw-1:0] : weight;
    prod  = psum_bw'(mac_product(PROD_W'(data), PROD_W'($signed(mul_w))));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      weight <= '0;
      loaded <= 1'b0;
      acc    <= '0;
      psum_s <= '0;
      valid  <= 1'b0;
      inst_e <= INST_NOP;
      mode_e <= 1'b0;
      data_e <= '0;
    end else begin
      inst_e <= inst;
      mode_e <= mode;
      data_e <= data;
      valid  <= 1'b0;
      if (dump) begin
        psum_s <= acc;
        acc    <= '0;
        valid  <= 1'b1;
      end else begin
        case (inst)
          INST_LOAD: begin
            // A captured load is consumed here so the next PE waits for the next value.
            if (!loaded) begin
              weight <= data;
              loaded <= 1'b1;
              inst_e <= INST_NOP;
            end
          end
          INST_EXEC: begin
            if (mode == MODE_OS) begin
              acc <= acc + prod;
            end else begin
              psum_s <= psum_n + prod;
              valid  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/mac_row_dm.sv
// rtl/mac_row_dm.sv - dual-mode WS/OS MAC row with skewed chain and drain FSM
module mac_row_dm
  import mac_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int col     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [bw-1:0]          in_w,
  input  logic [1:0]             inst_w,
  input  logic                   mode,
  input  logic                   drain,
  input  logic [psum_bw*col-1:0] in_n,
  output logic [psum_bw*col-1:0] out_s,
  output logic [col-1:0]         valid,
  output logic                   busy
);

  localparam int CW = $clog2(col + 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'((col > 1) ? (col - 2) : 0);

  drain_state_t  state, state_nx;
  logic [CW-1:0] cnt;
  logic          dump;

  logic [1:0]    inst_c [0:col];
  logic          mode_c [0:col];
  logic [bw-1:0] data_c [0:col];
  logic          unused_east;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == ST_FLUSH) ? cnt + 1'b1 : '0;
    end
  end

  // FLUSH lasts col-1 cycles so the op accepted with drain reaches the last PE before DUMP.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (drain) state_nx = (col == 1) ? ST_DUMP : ST_FLUSH;
      ST_FLUSH: if (cnt == FLUSH_LAST) state_nx = ST_DUMP;
      ST_DUMP:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
    dump = (state == ST_DUMP);
  end

  assign inst_c[0] = busy ? INST_NOP : inst_w;
  assign mode_c[0] = mode;
  assign data_c[0] = in_w;

  for (genvar i = 0; i < col; i++) begin : g_pe
    mac_pe_dm #(
      .bw      (bw),
      .psum_bw (psum_bw)
    ) u_pe (
      .clk    (clk),
      .reset  (reset),
      .inst   (inst_c[i]),
      .mode   (mode_c[i]),
      .data   (data_c[i]),
      .psum_n (in_n[i*psum_bw +: psum_bw]),
      .dump   (dump),
      .inst_e (inst_c[i+1]),
      .mode_e (mode_c[i+1]),
      .data_e (data_c[i+1]),
      .psum_s (out_s[i*psum_bw +: psum_bw]),
      .valid  (valid[i])
    );
  end

  assign unused_east = ^{inst_c[col], mode_c[col], data_c[col]};

endmodule
